// File: rtl/umem_arb_pkg.sv
// ============================================================================
// umem_arb_pkg : shared types and constants for the unified-memory arbiter
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package umem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

  // Byte offset of a doubleword within a byte address
  localparam int c_byte_ofs = 3;

endpackage

`default_nettype wire

// File: rtl/umem_arb_pick.sv
// ============================================================================
// umem_arb_pick : combinational request picker (UMEM_ARB_RR_EN selects
//                 round-robin, otherwise fixed data priority)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module umem_arb_pick
  import umem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  assign valid = i_req | d_req;

`ifdef UMEM_ARB_RR_EN
  // On a tie the port not served last wins
  always_comb begin
    grant = GNT_I;
    if (i_req && d_req) begin
      grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    end else if (d_req) begin
      grant = GNT_D;
    end
  end
`else
  logic w_unused_last;
  assign w_unused_last = last_grant;
  assign grant = d_req ? GNT_D : GNT_I;
`endif

endmodule

`default_nettype wire

// File: rtl/umem_arbiter.sv
// ============================================================================
// umem_arbiter : fetch/data arbiter and sequencer for a single-port unified
//                memory. Optional round-robin via macro UMEM_ARB_RR_EN.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module umem_arbiter
  import umem_arb_pkg::*;
#(
  parameter int ADDR_BITS = 6,
  parameter int MEM_LAT   = 1
)
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_req,
  input  logic [ADDR_BITS-1:0]            i_addr,
  output logic                            i_ack,
  output logic [31:0]                     i_rdata,
  input  logic                            d_req,
  input  logic                            d_we,
  input  logic [ADDR_BITS-1:0]            d_addr,
  input  logic [63:0]                     d_wdata,
  output logic                            d_ack,
  output logic [63:0]                     d_rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_BITS-c_byte_ofs-1:0] mem_addr,
  output logic [63:0]                     mem_wdata,
  input  logic [63:0]                     mem_rdata
);

  localparam int c_cnt_w = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(MEM_LAT - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_gnt;
  logic               r_we;
  logic               r_half;
  logic               w_valid;
  logic               w_grant;
  logic               w_last_grant;

  // Sub-doubleword address bits never reach the memory
  logic w_unused_addr;
  assign w_unused_addr = ^{i_addr[c_byte_ofs-2:0], d_addr[c_byte_ofs-1:0]};

  umem_arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (w_last_grant),
    .valid      (w_valid),
    .grant      (w_grant)
  );

`ifdef UMEM_ARB_RR_EN
  logic r_last_grant;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= GNT_I;
    end else if (r_state == IDLE && w_valid) begin
      r_last_grant <= w_grant;
    end
  end
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GNT_I;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gnt     <= GNT_I;
      r_we      <= 1'b0;
      r_half    <= 1'b0;
      i_ack     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_gnt  <= w_grant;
            r_half <= i_addr[c_byte_ofs-1];
            mem_en <= 1'b1;
            if (w_grant == GNT_D) begin
              r_we      <= d_we;
              mem_we    <= d_we;
              mem_addr  <= d_addr[ADDR_BITS-1:c_byte_ofs];
              mem_wdata <= d_we ? d_wdata : '0;
            end else begin
              r_we      <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= i_addr[ADDR_BITS-1:c_byte_ofs];
              mem_wdata <= '0;
            end
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          if (r_we) begin
            // Only the data port can write
            d_ack   <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt   <= c_cnt_init;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            if (r_gnt == GNT_D) begin
              d_ack   <= 1'b1;
              d_rdata <= mem_rdata;
            end else begin
              i_ack   <= 1'b1;
              i_rdata <= r_half ? mem_rdata[63:32] : mem_rdata[31:0];
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - c_cnt_w'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_umem_arbiter.sv
// ============================================================================
// tb_umem_arbiter : scoreboard bench for umem_arbiter (MEM_LAT = 1)
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_umem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [5:0]  i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  umem_arbiter #(.ADDR_BITS(6), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [63:0] data;
    int          cyc;
    bit          chk;
  } sb_t;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic        we;
    logic [63:0] wdata;
  } mem_rec_t;

  sb_t         i_q[$];
  sb_t         d_q[$];
  mem_rec_t    mem_log[$];
  bit          ack_order[$];
  logic [63:0] mem  [8];
  logic [63:0] gold [8];
  logic [31:0] exp_i_hold;
  logic [63:0] exp_d_hold;
  int          cyc;
  int          total;
  int          bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory model with one cycle of read latency
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    sb_t      e;
    mem_rec_t m;
    if (!mem_en) begin
      chk("mem_idle_zero", {63'b0, |{mem_we, mem_addr, mem_wdata}}, 64'd0);
    end else begin
      m.cyc = cyc; m.addr = mem_addr; m.we = mem_we; m.wdata = mem_wdata;
      mem_log.push_back(m);
    end
    if (i_ack) begin
      ack_order.push_back(1'b0);
      if (i_q.size() == 0) begin
        chk("i_ack_unexp", 64'd1, 64'd0);
      end else begin
        e = i_q.pop_front();
        chk("i_rdata", {32'b0, i_rdata}, e.data);
        if (e.cyc >= 0) chk("i_ack_cyc", 64'(cyc), 64'(e.cyc));
        exp_i_hold = e.data[31:0];
      end
      chk("d_hold", d_rdata, exp_d_hold);
    end
    if (d_ack) begin
      ack_order.push_back(1'b1);
      if (d_q.size() == 0) begin
        chk("d_ack_unexp", 64'd1, 64'd0);
      end else begin
        e = d_q.pop_front();
        if (e.chk) begin
          chk("d_rdata", d_rdata, e.data);
          exp_d_hold = e.data;
        end
        if (e.cyc >= 0) chk("d_ack_cyc", 64'(cyc), 64'(e.cyc));
      end
      chk("i_hold", {32'b0, i_rdata}, {32'b0, exp_i_hold});
    end
  end

  task automatic fetch(input logic [5:0] a, input int rel, output int t);
    sb_t e;
    int  n;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a; t = cyc;
    e.data = a[2] ? {32'b0, gold[a[5:3]][63:32]} : {32'b0, gold[a[5:3]][31:0]};
    e.cyc  = (rel < 0) ? -1 : t + rel;
    e.chk  = 1'b1;
    i_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!i_ack && n < 40);
    chk("i_done", {63'b0, i_ack}, 64'd1);
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic dacc(input logic we, input logic [5:0] a, input logic [63:0] w,
                      input int rel, output int t);
    sb_t e;
    int  n;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w; t = cyc;
    e.cyc = (rel < 0) ? -1 : t + rel;
    e.chk = !we;
    if (we) begin
      gold[a[5:3]] = w;
      e.data = '0;
    end else begin
      e.data = gold[a[5:3]];
    end
    d_q.push_back(e);
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 40);
    chk("d_done", {63'b0, d_ack}, 64'd1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
  endtask

  task automatic chk_mem(input int ecyc, input logic [2:0] ea, input logic ewe,
                         input logic [63:0] ewd);
    mem_rec_t m;
    if (mem_log.size() == 0) begin
      chk("mem_log_empty", 64'd1, 64'd0);
    end else begin
      m = mem_log.pop_front();
      chk("mem_cyc", 64'(m.cyc), 64'(ecyc));
      chk("mem_addr", {61'b0, m.addr}, {61'b0, ea});
      chk("mem_we", {63'b0, m.we}, {63'b0, ewe});
      if (ewe) chk("mem_wdata", m.wdata, ewd);
    end
  endtask

  initial begin
    int          t0;
    int          t1;
    int          n;
    int          acks;
    logic [3:0]  exp_ord;
    sb_t         e;

    total = 0; bad = 0; cyc = 0;
    exp_i_hold = '0; exp_d_hold = '0;
    rst_n = 1'b0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_rdata = '0;
    for (int k = 0; k < 8; k++) begin
      mem[k]  = {$urandom, $urandom};
      gold[k] = mem[k];
    end
    mem[1]  = 64'hAAAA_BBBB_1111_2222;
    gold[1] = mem[1];

    // Reset held with inputs toggling
    repeat (5) begin
      @(negedge clk);
      chk("rst_out", {63'b0, |{i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata}}, 64'd0);
      i_req = 1'($urandom); d_req = 1'($urandom); d_we = 1'($urandom);
      i_addr = 6'($urandom); d_addr = 6'($urandom); d_wdata = {$urandom, $urandom};
    end
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
    chk("rst_no_mem_en", 64'(mem_log.size()), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Fetch of the upper half of word 1
    mem_log.delete();
    fetch(6'h0C, 3, t0);
    chk_mem(t0 + 1, 3'd1, 1'b0, '0);

    // Tie: data wins, fetch follows after the next IDLE
    mem_log.delete();
    fork
      dacc(1'b0, 6'h08, '0, 3, t0);
      fetch(6'h00, 7, t1);
    join
    chk_mem(t0 + 1, 3'd1, 1'b0, '0);
    chk_mem(t0 + 5, 3'd0, 1'b0, '0);

    // Continuous contention for four grants
    mem_log.delete();
    ack_order.delete();
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'h08;
    i_req = 1'b1; i_addr = 6'h00;
    e.cyc = -1; e.chk = 1'b1;
`ifdef UMEM_ARB_RR_EN
    exp_ord = 4'b0101;
    repeat (2) begin
      e.data = gold[1];                d_q.push_back(e);
      e.data = {32'b0, gold[0][31:0]}; i_q.push_back(e);
    end
`else
    exp_ord = 4'b1111;
    repeat (4) begin
      e.data = gold[1]; d_q.push_back(e);
    end
`endif
    n = 0; acks = 0;
    while (acks < 4 && n < 80) begin
      @(negedge clk); n++;
      if (i_ack || d_ack) acks++;
    end
    @(posedge clk); #1;
    d_req = 1'b0; i_req = 1'b0;
    chk("ct_acks", 64'(ack_order.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ack_order.size()) chk("ct_order", {63'b0, ack_order[k]}, {63'b0, exp_ord[k]});
    end
    chk("ct_i_left", 64'(i_q.size()), 64'd0);
    chk("ct_d_left", 64'(d_q.size()), 64'd0);

    // Store then load back
    mem_log.delete();
    dacc(1'b1, 6'h10, 64'hDEAD_BEEF_0123_4567, 2, t0);
    chk_mem(t0 + 1, 3'd2, 1'b1, 64'hDEAD_BEEF_0123_4567);
    dacc(1'b0, 6'h10, '0, 3, t1);
    chk_mem(t1 + 1, 3'd2, 1'b0, '0);

    // Reset during WAIT drops the read
    mem_log.delete();
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 6'h0C;
    @(negedge clk);
    @(negedge clk);
    chk("mr_issue", {63'b0, mem_en}, 64'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    exp_i_hold = '0; exp_d_hold = '0;
    #1;
    chk("mr_rst_out", {63'b0, |{i_ack, i_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata}}, 64'd0);
    i_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    fetch(6'h08, 3, t0);

    repeat (3) @(negedge clk);
    chk("sb_i_empty", 64'(i_q.size()), 64'd0);
    chk("sb_d_empty", 64'(d_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/umem_arbiter.md
# umem_arbiter

Arbiter and sequencer for a single-port unified memory shared between the core's instruction-fetch port and data port. It accepts one request per port under a req/ack handshake and grants one access at a time. It sequences each access through issue, read-latency wait and response phases, and returns fetched words or load data to the owning port. It sits between the core datapath and the unified memory, replacing separate instruction and data memories.

## Interface
- ADDR_BITS, 6: byte-address width of both requester ports.
- MEM_LAT, 1: memory read latency in cycles, ≥1. Read data is valid MEM_LAT cycles after the cycle in which mem_en is high.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset. This is the one clock and reset; polarity and synchronicity are fixed.
- i_req  in  1  fetch request; held with i_addr stable until i_ack.
- i_addr  in  ADDR_BITS  fetch byte address.
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  out  32  fetched instruction.
- d_req  in  1  data request; held with d_we, d_addr and d_wdata stable until d_ack.
- d_we  in  1  1 means store, 0 means load.
- d_addr  in  ADDR_BITS  data byte address.
- d_wdata  in  64  store data.
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
- d_rdata  out  64  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_BITS-3  doubleword address.
- mem_wdata  out  64  write data.
- mem_rdata  in  64  read data.

## Operation
- FSM states:
  - IDLE: arbitrate among asserted requests. If any request is asserted, latch the grant, address, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: mem_en=1 for exactly one cycle. Next state is DONE for a write, WAIT for a read.
  - WAIT: MEM_LAT cycles, counted by a down-counter. Capture mem_rdata at the end of the last WAIT cycle. Next state is DONE.
  - DONE: pulse the ack of the granted port. Next state is IDLE.
- Address mapping: mem_addr = addr[ADDR_BITS-1:3].
  - Fetch: i_rdata = i_addr[2] ? captured[63:32] : captured[31:0]. i_addr[1:0] is ignored.
  - Data: d_addr[2:0] is ignored; accesses are always full 64-bit doublewords.
- Instruction port: reads only, mem_we=0.
- Arbitration: default is fixed data priority. A data access belongs to an older instruction, so it wins.
- DONE always returns to IDLE, so a request still held high during its own ack cycle is never re-granted.
- A port may assert a new request in the cycle after its ack.
- A request dropped before its ack is not aborted: the access completes and the ack still pulses.
- mem_we, mem_addr and mem_wdata are 0 whenever mem_en=0.
- i_rdata and d_rdata hold their value until the next ack on their own port.

## Timing
- Reset values: all outputs 0, state IDLE, WAIT counter 0, last-grant = instruction.
- Request sampled at the edge ending cycle T:
  - Read: mem_en in cycle T+1, ack in cycle T+2+MEM_LAT.
  - Write: mem_en and mem_we in cycle T+1, ack in cycle T+2.
- Back-to-back accesses: the next grant is sampled in the IDLE cycle, T+3+MEM_LAT for a read.
  - Read throughput: one access per MEM_LAT+3 cycles.
  - Write throughput: one access per 3 cycles.
- Reset mid-operation (any state) takes effect immediately:
  - State returns to IDLE and all outputs go to 0.
  - No ack is issued; the in-flight read is dropped.
  - After reset release, arbitration resumes normally.
- A simultaneous new request on the non-granted port is not visible until the next IDLE.

## Configuration
- UMEM_ARB_RR_EN defined: round-robin arbitration.
  - A last-grant flop records the port served last.
  - On a tie, the port not granted last wins; with a single requester, that requester wins.
  - The first tie after reset goes to data.
- UMEM_ARB_RR_EN undefined:
  - Fixed data priority.
  - The last-grant flop is not implemented.

## Structure
- Package umem_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DONE);
  - grant encoding GNT_I=1'b0, GNT_D=1'b1;
  - the byte-offset constant 3.
- Sub-module umem_arb_pick: combinational picker with inputs i_req, d_req and last_grant, and outputs valid and grant. The UMEM_ARB_RR_EN selection lives here.
- All remaining logic lives in umem_arbiter: FSM, latency counter, request latches, read capture and half-word select.

## Test plan
- Reset: hold rst_n=0 with all inputs toggling → every output is 0 and no mem_en appears.
- Fetch, MEM_LAT=1: i_req with i_addr=0x0C at cycle 0, memory word 1 = 0xAAAA_BBBB_1111_2222 → mem_en=1 and mem_addr=1 at cycle 1; i_ack at cycle 3 with i_rdata=0xAAAA_BBBB.
- Tie: d_req load at 0x08 and i_req at 0x00 both asserted at cycle 0 → d_ack at cycle 3, then mem_en for the fetch at cycle 5, i_ack at cycle 7.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0xDEAD_BEEF_0123_4567 → mem_en, mem_we and mem_addr=2 at cycle 1, d_ack at cycle 2. A following load of 0x10 returns the same value.
- Contention: d_req and i_req held continuously for 4 grants → order D,I,D,I with UMEM_ARB_RR_EN; D,D,D,D with i_ack never pulsing without it.
- Mid-read reset: assert rst_n=0 during WAIT → no ack is issued and outputs go to 0. After release, a fresh i_req completes with standard latency.
